// File: rtl/mem_pkg.sv
// Shared constants and types for the memory BIST initiator and its pattern generator.
package mem_pkg;

    localparam int WIDTH      = 16;
    localparam int DEPTH      = 512;
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int ERR_W      = 8;
    localparam int TIMEOUT    = 64;

    localparam logic [1:0] MODE_NOP  = 2'b00;
    localparam logic [1:0] MODE_WR   = 2'b01;
    localparam logic [1:0] MODE_RD   = 2'b10;
    localparam logic [1:0] MODE_WRRD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Encoded so the pass value drives wr_rd directly.
    typedef enum logic {
        PASS_READ  = 1'b0,
        PASS_WRITE = 1'b1
    } pass_t;

endpackage

// File: rtl/mem_pattern_gen.sv
// Combinational pattern source: wrapped address base+index and expected word seed+index.
module mem_pattern_gen
    import mem_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH:0]   index,
    input  logic [WIDTH-1:0]      seed,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      expected
);

    // DEPTH is a power of two, so dropping the carry is the modulo-DEPTH wrap.
    assign addr     = base + index[ADDR_WIDTH-1:0];
    assign expected = seed + {{(WIDTH-ADDR_WIDTH-1){1'b0}}, index};

endmodule

// File: rtl/mem_bist_initiator.sv
// Memory BIST initiator: fill, read-verify or fill-then-verify a wrapped address range.
// Optional watchdog abort is enabled by defining MEM_BIST_TIMEOUT_EN (adds timeout_o).
module mem_bist_initiator
    import mem_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            mode_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic [WIDTH-1:0]      seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ERR_W-1:0]      err_cnt_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] first_fail_addr_o,
    output logic [WIDTH-1:0]      first_fail_data_o,
    output logic                  valid_o,
    output logic                  wr_rd_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
`ifdef MEM_BIST_TIMEOUT_EN
    output logic                  timeout_o,
`endif
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rdata_i
);

    // Handshake: valid_o rises in REQ and request fields stay frozen until ready_i=1 is
    // sampled; GAP then waits for ready_i=0 so a stale ready never completes a new request.

    state_t                state, state_next;
    pass_t                 pass;
    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [WIDTH-1:0]      seed_q;
    logic [ADDR_WIDTH:0]   index;
    logic [ADDR_WIDTH:0]   idx_inc;
    logic [ERR_W-1:0]      err_cnt;
    logic                  fail;
    logic [ADDR_WIDTH-1:0] ff_addr;
    logic [WIDTH-1:0]      ff_data;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic [WIDTH-1:0]      expected;
    logic                  load, cmp_en, advance, restart, tmo_hit;

    mem_pattern_gen u_pattern_gen (
        .base     (base_q),
        .index    (index),
        .seed     (seed_q),
        .addr     (gen_addr),
        .expected (expected)
    );

    assign idx_inc = index + 1'b1;

`ifdef MEM_BIST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT);
    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        cmp_en     = 1'b0;
        advance    = 1'b0;
        restart    = 1'b0;
        tmo_hit    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    load = 1'b1;
                    if (mode_i == MODE_NOP || len_i == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (ready_i) begin
                    cmp_en     = (pass == PASS_READ);
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!ready_i) begin
                    if (idx_inc < len_q) begin
                        advance    = 1'b1;
                        state_next = ST_REQ;
                    end else if (pass == PASS_WRITE && mode_q == MODE_WRRD) begin
                        restart    = 1'b1;
                        state_next = ST_REQ;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
`ifdef MEM_BIST_TIMEOUT_EN
        // Watchdog only fires while the FSM is stuck in one state.
        if ((state == ST_REQ || state == ST_GAP) && state_next == state &&
            tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            tmo_hit    = 1'b1;
            state_next = ST_DONE;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pass    <= PASS_READ;
            mode_q  <= MODE_NOP;
            base_q  <= '0;
            len_q   <= '0;
            seed_q  <= '0;
            index   <= '0;
            err_cnt <= '0;
            fail    <= 1'b0;
            ff_addr <= '0;
            ff_data <= '0;
        end else begin
            if (load) begin
                mode_q  <= mode_i;
                base_q  <= base_addr_i;
                len_q   <= len_i;
                seed_q  <= seed_i;
                index   <= '0;
                pass    <= (mode_i == MODE_RD) ? PASS_READ : PASS_WRITE;
                err_cnt <= '0;
                fail    <= 1'b0;
                ff_addr <= '0;
                ff_data <= '0;
            end
            if (advance) begin
                index <= idx_inc;
            end
            if (restart) begin
                index <= '0;
                pass  <= PASS_READ;
            end
            if (cmp_en && rdata_i != expected) begin
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (!fail) begin
                    fail    <= 1'b1;
                    ff_addr <= gen_addr;
                    ff_data <= rdata_i;
                end
            end
            if (tmo_hit) begin
                fail <= 1'b1;
            end
        end
    end

`ifdef MEM_BIST_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            if (state_next != state || (state != ST_REQ && state != ST_GAP)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (load) begin
                timeout <= 1'b0;
            end else if (tmo_hit) begin
                timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout;
`endif

    // Request fields are zeroed outside REQ so reset and idle present all-zero outputs.
    assign valid_o           = (state == ST_REQ);
    assign wr_rd_o           = valid_o && (pass == PASS_WRITE);
    assign addr_o            = valid_o ? gen_addr : '0;
    assign wdata_o           = valid_o ? expected : '0;
    assign busy_o            = (state == ST_REQ) || (state == ST_GAP);
    assign done_o            = (state == ST_DONE);
    assign err_cnt_o         = err_cnt;
    assign fail_o            = fail;
    assign first_fail_addr_o = ff_addr;
    assign first_fail_data_o = ff_data;

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Self-checking bench for mem_bist_initiator with a registered-ready memory model.
// Build with MEM_BIST_TIMEOUT_EN defined to also exercise the watchdog abort.
module tb_mem_bist_initiator;
    import mem_pkg::*;

    localparam int LW = ADDR_WIDTH + 1;
    localparam int RW = 1 + ADDR_WIDTH + WIDTH;

    logic                  clk = 1'b0;
    logic                  rst_i = 1'b1;
    logic                  start_i = 1'b0;
    logic [1:0]            mode_i = '0;
    logic [ADDR_WIDTH-1:0] base_addr_i = '0;
    logic [LW-1:0]         len_i = '0;
    logic [WIDTH-1:0]      seed_i = '0;
    logic                  busy_o, done_o, fail_o, valid_o, wr_rd_o;
    logic [ERR_W-1:0]      err_cnt_o;
    logic [ADDR_WIDTH-1:0] first_fail_addr_o, addr_o;
    logic [WIDTH-1:0]      first_fail_data_o, wdata_o;
    logic                  ready_i;
    logic [WIDTH-1:0]      rdata_i;
`ifdef MEM_BIST_TIMEOUT_EN
    logic                  timeout_o;
`endif

    // clock / reset
    always #5 clk = ~clk;

    mem_bist_initiator dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .mode_i            (mode_i),
        .base_addr_i       (base_addr_i),
        .len_i             (len_i),
        .seed_i            (seed_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_cnt_o         (err_cnt_o),
        .fail_o            (fail_o),
        .first_fail_addr_o (first_fail_addr_o),
        .first_fail_data_o (first_fail_data_o),
        .valid_o           (valid_o),
        .wr_rd_o           (wr_rd_o),
        .addr_o            (addr_o),
        .wdata_o           (wdata_o),
`ifdef MEM_BIST_TIMEOUT_EN
        .timeout_o         (timeout_o),
`endif
        .ready_i           (ready_i),
        .rdata_i           (rdata_i)
    );

    // memory model: ready one cycle after valid, operation repeated while valid is held
    logic [WIDTH-1:0]      mem [DEPTH];
    logic                  ready_q = 1'b0;
    logic [WIDTH-1:0]      rdata_q = '0;
    logic                  stall = 1'b0;
    logic                  poke_en = 1'b0;
    logic [ADDR_WIDTH-1:0] poke_addr = '0;
    logic [WIDTH-1:0]      poke_data = '0;

    always @(posedge clk) begin
        ready_q <= valid_o && !stall;
        if (valid_o && !stall) begin
            if (wr_rd_o) mem[addr_o] <= wdata_o;
            rdata_q <= mem[addr_o];
        end
        if (poke_en) mem[poke_addr] <= poke_data;
    end
    assign ready_i = ready_q;
    assign rdata_i = rdata_q;

    // scoreboard
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] item;
    int            checks = 0;
    int            errors = 0;
    int            valid_rises = 0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [RW-1:0] prev_req = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            if (valid_o && !prev_valid) valid_rises <= valid_rises + 1;
            if (prev_valid && !prev_ready && !done_o)
                check("req_hold", {valid_o, wr_rd_o, addr_o, wdata_o}, {1'b1, prev_req});
            if (valid_o && ready_i) begin
                check("req_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    item = exp_q.pop_front();
                    check("req_fields", {wr_rd_o, addr_o, wdata_o}, item);
                end
            end
        end
        prev_valid <= valid_o && !rst_i;
        prev_ready <= ready_i;
        prev_req   <= {wr_rd_o, addr_o, wdata_o};
    end

    // driver tasks
    task automatic push_exp(input logic [1:0] mode, input int base, input int len,
                            input logic [WIDTH-1:0] seed);
        if (mode == MODE_NOP || len == 0) return;
        for (int p = 0; p < 2; p++) begin
            if ((p == 0 && mode[0]) || (p == 1 && mode[1])) begin
                for (int i = 0; i < len; i++)
                    exp_q.push_back({p == 0, ADDR_WIDTH'(base + i), WIDTH'(int'(seed) + i)});
            end
        end
    endtask

    task automatic run_cmd(input logic [1:0] mode, input int base, input int len,
                           input logic [WIDTH-1:0] seed, input bit poke);
        int words, lat, rises0;
        bit seen;
        words  = (mode == MODE_NOP || len == 0) ? 0 : len * ((mode == MODE_WRRD) ? 2 : 1);
        push_exp(mode, base, len, seed);
        rises0 = valid_rises;
        @(negedge clk);
        start_i     = 1'b1;
        mode_i      = mode;
        base_addr_i = ADDR_WIDTH'(base);
        len_i       = LW'(len);
        seed_i      = seed;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 4 * words + 10) begin
            @(posedge clk);
            #1;
            lat++;
            start_i = 1'b0;
            if (lat == 1) check("busy_start", busy_o, words != 0);
            if (done_o) seen = 1'b1;
            if (poke && lat == 6) begin
                start_i = 1'b1;
                mode_i  = MODE_NOP;
                len_i   = '0;
            end
        end
        check("done_seen", seen, 1);
        check("latency", lat, 4 * words + 1);
        @(posedge clk);
        #1;
        check("done_one_cycle", done_o, 0);
        check("busy_end", busy_o, 0);
        @(negedge clk);
        check("valid_pulses", valid_rises - rises0, words);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_result(input int err, input bit fail, input int fa, input int fd);
        check("err_cnt", err_cnt_o, err);
        check("fail", fail_o, fail);
        check("first_fail_addr", first_fail_addr_o, fa);
        check("first_fail_data", first_fail_data_o, fd);
    endtask

    initial begin : main
        int            base, len;
        logic [15:0]   seed;
        bit            seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check_result(0, 0, 0, 0);
        @(negedge clk);
        rst_i = 1'b0;

        // fill 10..13, with an ignored start pulse mid-command
        run_cmd(MODE_WR, 10, 4, 16'h1000, 1'b1);
        check_result(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) check("fill_word", mem[10 + i], 16'h1000 + i);

        // corrupt word 12 and read-verify
        @(negedge clk);
        poke_en = 1'b1; poke_addr = 12; poke_data = 16'hDEAD;
        @(negedge clk);
        poke_en = 1'b0;
        run_cmd(MODE_RD, 10, 4, 16'h1000, 1'b0);
        check_result(1, 1, 12, 16'hDEAD);

        // wrap of address and data, write then verify
        run_cmd(MODE_WRRD, 508, 8, 16'hFFFE, 1'b0);
        check_result(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) check("wrap_word", mem[(508 + i) % DEPTH], (16'hFFFE + i) & 16'hFFFF);

        // no-op commands
        run_cmd(MODE_NOP, 5, 3, 16'h0, 1'b0);
        run_cmd(MODE_WRRD, 5, 0, 16'h0, 1'b0);

        // reset during REQ of a mode-11 run
        push_exp(MODE_WRRD, 0, 8, 16'h0055);
        @(negedge clk);
        start_i = 1'b1; mode_i = MODE_WRRD; base_addr_i = 0; len_i = 8; seed_i = 16'h0055;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (valid_o && !ready_i && dut.index != 0) seen = 1'b1;
        end
        check("reached_req", seen, 1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("abort_outputs", {valid_o, busy_o, done_o, wr_rd_o, addr_o, wdata_o}, 0);
        check_result(0, 0, 0, 0);
        @(negedge clk);
        rst_i = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        run_cmd(MODE_WRRD, 100, 3, 16'h0AB0, 1'b0);
        check_result(0, 0, 0, 0);

        // randomised write-then-verify runs
        for (int r = 0; r < 3; r++) begin
            base = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(1, 20);
            seed = 16'($urandom_range(0, 65535));
            run_cmd(MODE_WRRD, base, len, seed, 1'b0);
            check_result(0, 0, 0, 0);
        end

        // error counter saturation: every word mismatches
        run_cmd(MODE_WR, 0, 300, 16'h0000, 1'b0);
        run_cmd(MODE_RD, 0, 300, 16'h8000, 1'b0);
        check_result(255, 1, 0, 16'h0000);

        // full depth from a non-zero base covers every word once
        seed = 16'($urandom_range(0, 65535));
        run_cmd(MODE_WRRD, 300, DEPTH, seed, 1'b0);
        check_result(0, 0, 0, 0);
        for (int a = 0; a < DEPTH; a++)
            check("full_word", mem[a], 16'(int'(seed) + ((a - 300 + DEPTH) % DEPTH)));

`ifdef MEM_BIST_TIMEOUT_EN
        // watchdog: memory never answers
        stall = 1'b1;
        @(negedge clk);
        start_i = 1'b1; mode_i = MODE_WR; base_addr_i = 0; len_i = 2; seed_i = 0;
        seen = 1'b0;
        begin : tmo_wait
            int lat;
            lat = 0;
            while (!seen && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
                start_i = 1'b0;
                if (done_o) seen = 1'b1;
            end
            check("tmo_done", seen, 1);
            check("tmo_latency", lat, TIMEOUT + 1);
        end
        check("tmo_flag", timeout_o, 1);
        check("tmo_fail", fail_o, 1);
        check("tmo_valid", valid_o, 0);
        stall = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
